// File: rtl/rom_horner_eval_if.sv
// Handshake and ROM bus for the Horner polynomial sequencer.
// master = requester plus coefficient ROM, slave = sequencer.
interface rom_horner_eval_if;
  logic               start;
  logic signed [15:0] x;
  logic [2:0]         rom_sel;
  logic signed [15:0] rom_data;
  logic               busy;
  logic               done;
  logic signed [15:0] result;
  logic               sat;

  modport master (
    output start, x, rom_data,
    input  rom_sel, busy, done, result, sat
  );

  modport slave (
    input  start, x, rom_data,
    output rom_sel, busy, done, result, sat
  );
endinterface

// File: rtl/rom_horner_eval.sv
// Horner-rule polynomial evaluator over an 8x16 coefficient ROM.
// Fixed-point with FRAC fraction bits, saturating after every step.
module rom_horner_eval #(
  parameter int NUM_COEF = 7,
  parameter int FRAC     = 10
) (
  input  logic             clk,
  input  logic             rst,
  rom_horner_eval_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_COEF - 1);

  state_t             r_state;
  logic [2:0]         r_idx;
  logic signed [15:0] r_acc;
  logic signed [15:0] r_xr;
  logic               r_flag;
  logic               r_busy;
  logic               r_done;
  logic signed [15:0] r_result;
  logic               r_sat;

  logic signed [31:0] w_p;
  logic signed [32:0] w_pe;
  logic signed [32:0] w_ce;
  logic signed [32:0] w_s;
  logic               w_hi;
  logic               w_lo;
  logic               w_clip;
  logic signed [15:0] w_next;

  // One Horner step: acc*x rescaled (floor), plus the next coefficient.
  assign w_p    = r_acc * r_xr;
  assign w_pe   = {w_p[31], w_p};
  assign w_ce   = {{17{bus.rom_data[15]}}, bus.rom_data};
  assign w_s    = (w_pe >>> FRAC) + w_ce;
  assign w_hi   = (w_s > 33'sd32767);
  assign w_lo   = (w_s < -33'sd32768);
  assign w_clip = w_hi | w_lo;
  assign w_next = w_hi ? 16'sh7fff :
                  w_lo ? 16'sh8000 :
                  w_s[15:0];

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= 3'd0;
      r_acc    <= 16'sd0;
      r_xr     <= 16'sd0;
      r_flag   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 16'sd0;
      r_sat    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_xr    <= bus.x;
            r_idx   <= 3'd0;
            r_flag  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_acc   <= bus.rom_data;
          r_idx   <= 3'd1;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc  <= w_next;
          r_flag <= r_flag | w_clip;
          if (r_idx == LAST_IDX) begin
            r_done   <= 1'b1;
            r_result <= w_next;
            r_sat    <= r_flag | w_clip;
            r_state  <= S_DONE;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_sel = r_idx;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.sat     = r_sat;

endmodule
